exp_irq_ctrl: RTL and testbench

//  Parametrised exception/interrupt controller for the next-gen CPU core, generalising the fixed
//  3-source ExpSrc0..2/HasExp/ExpBlock scheme. Latches NSRC sources, masks, priority-selects,
//  and redirects the PC at an instruction boundary. Nests up to DEPTH levels on an EPC/ID stack.

---
 rtl/exp_pkg.sv | 18 +
 rtl/exp_irq_ctrl_prio_enc.sv | 25 ++
 rtl/exp_irq_ctrl.sv | 135 +++++++++++++
 tb/tb_exp_irq_ctrl.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/exp_pkg.sv
// Shared types and constants for the exception/interrupt controller.
package exp_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKEN   = 2'd1,
    SERVICE = 2'd2
  } state_t;

  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0800;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0010;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idWidth(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/exp_irq_ctrl_prio_enc.sv
// Lowest-index-first priority encoder: index 0 is the highest priority.
module prio_enc
  import exp_pkg::*;
#(
  parameter int N = 3,
  parameter int W = idWidth(N)
) (
  input  logic [N-1:0] req,
  output logic         valid,
  output logic [W-1:0] id
);

  // Scan from the top index down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = W'(i);
      end
    end
  end

endmodule

// File: rtl/exp_irq_ctrl.sv
// Exception/interrupt controller: latches sources, masks and priority-selects
// them, redirects the PC at an instruction boundary and nests handlers on an
// EPC/ID stack up to DEPTH levels deep.
module exp_irq_ctrl
  import exp_pkg::*;
#(
  parameter int              NSRC       = 3,
  parameter int              DEPTH      = 2,
  parameter logic [NSRC-1:0] LEVEL_MASK = '0,
  parameter logic [NSRC-1:0] MASK_RST   = '1,
  parameter logic [31:0]     VEC_BASE   = VEC_BASE_DEF,
  parameter logic [31:0]     VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NSRC-1:0]            src_in,
  input  logic                       mask_we,
  input  logic [NSRC-1:0]            mask_din,
  input  logic                       clr_we,
  input  logic [NSRC-1:0]            clr_din,
  input  logic [31:0]                pc_cur,
  input  logic                       inst_retire,
  input  logic                       eret,
  output logic                       irq_take,
  output logic [31:0]                irq_vec,
  output logic [idWidth(NSRC)-1:0]   irq_id,
  output logic [31:0]                epc,
  output logic                       in_service,
  output logic [NSRC-1:0]            pending,
  output logic [NSRC-1:0]            mask
);

  localparam int IDW = idWidth(NSRC);
  localparam int DW  = $clog2(DEPTH + 1);
  localparam int AW  = idWidth(DEPTH);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [DW-1:0] DEPTH_ONE = DW'(1);

  state_t          state, stateNext;
  logic [NSRC-1:0] srcHist;
  logic [NSRC-1:0] reqVec, clrVec, takeVec, edgeVec, pendNext;
  logic [DW-1:0]   depth;
  logic [AW-1:0]   topIdx, pushIdx;
  logic [31:0]     epcStk [DEPTH];
  logic [IDW-1:0]  idStk  [DEPTH];
  logic            candValid;
  logic [IDW-1:0]  candId;
  logic            eligible, takeNow, popNow;

  assign reqVec = pending & mask;

  prio_enc #(.N(NSRC), .W(IDW)) uPrioEnc (
    .req   (reqVec),
    .valid (candValid),
    .id    (candId)
  );

  assign topIdx  = AW'(depth - 1'b1);
  assign pushIdx = AW'(depth);

  // A nested take needs strictly higher priority than the handler at the top.
  assign eligible = (depth == '0) || (candId < idStk[topIdx]);
  // eret in the same cycle suppresses the take; it is re-evaluated after the pop.
  assign takeNow  = (state != TAKEN) && candValid && eligible &&
                    (depth != DEPTH_MAX) && inst_retire && !eret;
  assign popNow   = eret && (state == SERVICE) && (depth != '0);

  assign epc        = (depth == '0) ? 32'h0 : epcStk[topIdx];
  assign in_service = (depth != '0);

  // Next pending: edge bits set on a rise (set beats clear), level bits follow src_in.
  always_comb begin
    clrVec  = clr_we ? clr_din : '0;
    takeVec = '0;
    if (takeNow) takeVec[candId] = 1'b1;
    edgeVec  = src_in & ~srcHist;
    pendNext = (((pending & ~clrVec & ~takeVec) | edgeVec) & ~LEVEL_MASK) |
               (src_in & LEVEL_MASK);
  end

  // FSM next state: a take always passes through TAKEN for exactly one cycle.
  always_comb begin
    stateNext = state;
    if (takeNow) begin
      stateNext = TAKEN;
    end else begin
      case (state)
        TAKEN:   stateNext = SERVICE;
        SERVICE: if (popNow && (depth == DEPTH_ONE)) stateNext = IDLE;
        default: stateNext = state;
      endcase
    end
  end

  // Control registers: FSM, nesting depth, pending/mask, edge history, redirect outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      depth    <= '0;
      srcHist  <= '0;
      pending  <= '0;
      mask     <= MASK_RST;
      irq_take <= 1'b0;
      irq_id   <= '0;
      irq_vec  <= VEC_BASE;
    end else begin
      state    <= stateNext;
      srcHist  <= src_in;
      pending  <= pendNext;
      irq_take <= takeNow;
      if (mask_we) mask <= mask_din;
      if (takeNow) begin
        irq_id  <= candId;
        irq_vec <= VEC_BASE + 32'(candId) * VEC_STRIDE;
        depth   <= depth + 1'b1;
      end else if (popNow) begin
        depth <= depth - 1'b1;
      end
    end
  end

  // EPC/ID stack storage: written on push; a pop only moves the depth counter.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        epcStk[i] <= 32'h0;
        idStk[i]  <= '0;
      end
    end else if (takeNow) begin
      epcStk[pushIdx] <= pc_cur;
      idStk[pushIdx]  <= candId;
    end
  end

endmodule

// File: tb/tb_exp_irq_ctrl.sv
// Bench for exp_irq_ctrl (NSRC=3, DEPTH=2, all sources edge-sensitive).
module tb_exp_irq_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  src_in = '0;
  logic        mask_we = 1'b0;
  logic [2:0]  mask_din = '0;
  logic        clr_we = 1'b0;
  logic [2:0]  clr_din = '0;
  logic [31:0] pc_cur = '0;
  logic        inst_retire = 1'b0;
  logic        eret = 1'b0;
  logic        irq_take;
  logic [31:0] irq_vec;
  logic [1:0]  irq_id;
  logic [31:0] epc;
  logic        in_service;
  logic [2:0]  pending;
  logic [2:0]  mask;

  exp_irq_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .src_in      (src_in),
    .mask_we     (mask_we),
    .mask_din    (mask_din),
    .clr_we      (clr_we),
    .clr_din     (clr_din),
    .pc_cur      (pc_cur),
    .inst_retire (inst_retire),
    .eret        (eret),
    .irq_take    (irq_take),
    .irq_vec     (irq_vec),
    .irq_id      (irq_id),
    .epc         (epc),
    .in_service  (in_service),
    .pending     (pending),
    .mask        (mask)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] vec;
    logic [31:0] epc;
  } take_t;

  take_t expQ[$];
  take_t mon;
  int    checks  = 0;
  int    errors  = 0;
  int    takeCnt = 0;

  function automatic take_t mkTake(input logic [1:0] id, input logic [31:0] pc);
    take_t t;
    t.id  = id;
    t.vec = 32'h0000_0800 + {30'd0, id} * 32'h0000_0010;
    t.epc = pc;
    return t;
  endfunction

  // Scoreboard consumer: every redirect pulse must match the oldest expected take.
  always @(posedge clk) begin
    #2;
    if (irq_take === 1'b1) begin
      takeCnt++;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("FAIL unexpected_take: got id=%0d vec=%h epc=%h, none expected", irq_id, irq_vec, epc);
      end else begin
        mon = expQ.pop_front();
        if ({irq_id, irq_vec, epc} !== {mon.id, mon.vec, mon.epc}) begin
          errors++;
          $display("FAIL take_content: got id=%0d vec=%h epc=%h want id=%0d vec=%h epc=%h",
                   irq_id, irq_vec, epc, mon.id, mon.vec, mon.epc);
        end
      end
    end
  end

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (irq_take !== 1'b0) begin errors++; $display("FAIL reset_take: got %b want 0", irq_take); end
    checks++; if (irq_vec !== 32'h800) begin errors++; $display("FAIL reset_vec: got %h want 00000800", irq_vec); end
    checks++; if (irq_id !== 2'd0) begin errors++; $display("FAIL reset_id: got %0d want 0", irq_id); end
    checks++; if (epc !== 32'h0) begin errors++; $display("FAIL reset_epc: got %h want 0", epc); end
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL reset_insvc: got %b want 0", in_service); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL reset_pending: got %b want 000", pending); end
    checks++; if (mask !== 3'b111) begin errors++; $display("FAIL reset_mask: got %b want 111", mask); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int base;
    base = takeCnt;
    pc_cur = 32'h1000_0040; inst_retire = 1'b1; src_in = 3'b010;
    expQ.push_back(mkTake(2'd1, 32'h1000_0040));
    @(negedge clk);
    src_in = 3'b000;
    checks++; if (pending !== 3'b010) begin errors++; $display("FAIL single_pending_set: got %b want 010", pending); end
    checks++; if (irq_take !== 1'b0) begin errors++; $display("FAIL single_early_take: got %b want 0", irq_take); end
    @(negedge clk);
    checks++; if (irq_take !== 1'b1) begin errors++; $display("FAIL single_take: got %b want 1", irq_take); end
    checks++; if (irq_vec !== 32'h810) begin errors++; $display("FAIL single_vec: got %h want 00000810", irq_vec); end
    checks++; if (epc !== 32'h1000_0040) begin errors++; $display("FAIL single_epc: got %h want 10000040", epc); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL single_pending_clr: got %b want 000", pending); end
    checks++; if (takeCnt !== base + 1) begin errors++; $display("FAIL single_count: got %0d want %0d", takeCnt, base + 1); end
    @(negedge clk);
    checks++; if (irq_take !== 1'b0) begin errors++; $display("FAIL single_pulse_width: got %b want 0", irq_take); end
    eret = 1'b1; @(negedge clk); eret = 1'b0;
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL single_eret_insvc: got %b want 0", in_service); end
    checks++; if (epc !== 32'h0) begin errors++; $display("FAIL single_eret_epc: got %h want 0", epc); end
  endtask

  task automatic test_nested();
    int base;
    base = takeCnt;
    pc_cur = 32'h0000_2000; src_in = 3'b100; inst_retire = 1'b1;
    expQ.push_back(mkTake(2'd2, 32'h0000_2000));
    for (int i = 0; i < 8 && takeCnt < base + 1; i++) @(negedge clk);
    checks++; if (takeCnt !== base + 1) begin errors++; $display("FAIL nest_first_take: got %0d takes want %0d", takeCnt, base + 1); end
    src_in = 3'b000;
    @(negedge clk);
    pc_cur = 32'h0000_3000; src_in = 3'b001;
    expQ.push_back(mkTake(2'd0, 32'h0000_3000));
    for (int i = 0; i < 8 && takeCnt < base + 2; i++) @(negedge clk);
    checks++; if (takeCnt !== base + 2) begin errors++; $display("FAIL nest_second_take: got %0d takes want %0d", takeCnt, base + 2); end
    checks++; if (epc !== 32'h3000) begin errors++; $display("FAIL nest_epc_top: got %h want 00003000", epc); end
    src_in = 3'b000;
    @(negedge clk);
    eret = 1'b1; @(negedge clk); eret = 1'b0;
    checks++; if (epc !== 32'h2000) begin errors++; $display("FAIL nest_epc_restore: got %h want 00002000", epc); end
    checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL nest_still_insvc: got %b want 1", in_service); end
    eret = 1'b1; @(negedge clk); eret = 1'b0;
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL nest_final_insvc: got %b want 0", in_service); end
  endtask

  task automatic test_full();
    int base;
    base = takeCnt;
    pc_cur = 32'h0000_4000; src_in = 3'b100; inst_retire = 1'b1;
    expQ.push_back(mkTake(2'd2, 32'h0000_4000));
    for (int i = 0; i < 8 && takeCnt < base + 1; i++) @(negedge clk);
    src_in = 3'b000;
    @(negedge clk);
    pc_cur = 32'h0000_4100; src_in = 3'b010;
    expQ.push_back(mkTake(2'd1, 32'h0000_4100));
    for (int i = 0; i < 8 && takeCnt < base + 2; i++) @(negedge clk);
    checks++; if (takeCnt !== base + 2) begin errors++; $display("FAIL full_fill: got %0d takes want %0d", takeCnt, base + 2); end
    src_in = 3'b000;
    @(negedge clk);
    pc_cur = 32'h0000_4200; src_in = 3'b001;
    repeat (4) @(negedge clk);
    checks++; if (takeCnt !== base + 2) begin errors++; $display("FAIL full_blocked: got %0d takes want %0d", takeCnt, base + 2); end
    checks++; if (pending !== 3'b001) begin errors++; $display("FAIL full_pending_kept: got %b want 001", pending); end
    checks++; if (epc !== 32'h4100) begin errors++; $display("FAIL full_epc: got %h want 00004100", epc); end
    expQ.push_back(mkTake(2'd0, 32'h0000_4200));
    eret = 1'b1; @(negedge clk); eret = 1'b0;
    checks++; if (epc !== 32'h4000) begin errors++; $display("FAIL full_pop_epc: got %h want 00004000", epc); end
    checks++; if (irq_take !== 1'b0) begin errors++; $display("FAIL full_pop_take_early: got %b want 0", irq_take); end
    @(negedge clk);
    checks++; if (irq_take !== 1'b1) begin errors++; $display("FAIL full_take_after_pop: got %b want 1", irq_take); end
    checks++; if (epc !== 32'h4200) begin errors++; $display("FAIL full_new_epc: got %h want 00004200", epc); end
    src_in = 3'b000;
    @(negedge clk);
    eret = 1'b1; @(negedge clk); eret = 1'b0;
    eret = 1'b1; @(negedge clk); eret = 1'b0;
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL full_unwind: got %b want 0", in_service); end
  endtask

  task automatic test_eret_and_mask();
    int base;
    base = takeCnt;
    pc_cur = 32'h0000_5000; src_in = 3'b100; inst_retire = 1'b1;
    expQ.push_back(mkTake(2'd2, 32'h0000_5000));
    for (int i = 0; i < 8 && takeCnt < base + 1; i++) @(negedge clk);
    src_in = 3'b000; inst_retire = 1'b0;
    @(negedge clk);
    src_in = 3'b010; pc_cur = 32'h0000_5100;
    @(negedge clk);
    checks++; if (pending !== 3'b010) begin errors++; $display("FAIL eret_pending: got %b want 010", pending); end
    expQ.push_back(mkTake(2'd1, 32'h0000_5100));
    eret = 1'b1; inst_retire = 1'b1;
    @(negedge clk);
    eret = 1'b0;
    checks++; if (irq_take !== 1'b0) begin errors++; $display("FAIL eret_wins: got %b want 0", irq_take); end
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL eret_popped: got %b want 0", in_service); end
    @(negedge clk);
    checks++; if (irq_take !== 1'b1) begin errors++; $display("FAIL eret_then_take: got %b want 1", irq_take); end
    checks++; if (irq_id !== 2'd1) begin errors++; $display("FAIL eret_then_id: got %0d want 1", irq_id); end
    src_in = 3'b000;
    @(negedge clk);
    eret = 1'b1; @(negedge clk); eret = 1'b0;
    base = takeCnt;
    mask_we = 1'b1; mask_din = 3'b101;
    @(negedge clk);
    mask_we = 1'b0; pc_cur = 32'h0000_5200; src_in = 3'b010;
    repeat (5) @(negedge clk);
    checks++; if (takeCnt !== base) begin errors++; $display("FAIL mask_blocks: got %0d takes want %0d", takeCnt, base); end
    checks++; if (pending !== 3'b010) begin errors++; $display("FAIL mask_pending: got %b want 010", pending); end
    checks++; if (mask !== 3'b101) begin errors++; $display("FAIL mask_value: got %b want 101", mask); end
    expQ.push_back(mkTake(2'd1, 32'h0000_5200));
    mask_we = 1'b1; mask_din = 3'b111;
    @(negedge clk);
    mask_we = 1'b0;
    for (int i = 0; i < 8 && takeCnt < base + 1; i++) @(negedge clk);
    checks++; if (takeCnt !== base + 1) begin errors++; $display("FAIL unmask_take: got %0d takes want %0d", takeCnt, base + 1); end
    src_in = 3'b000;
    @(negedge clk);
    eret = 1'b1; @(negedge clk); eret = 1'b0;
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL mask_unwind: got %b want 0", in_service); end
  endtask

  task automatic test_clr_and_reset();
    int base;
    base = takeCnt;
    inst_retire = 1'b0; src_in = 3'b100; clr_we = 1'b1; clr_din = 3'b100;
    @(negedge clk);
    clr_we = 1'b0;
    checks++; if (pending !== 3'b100) begin errors++; $display("FAIL set_beats_clr: got %b want 100", pending); end
    clr_we = 1'b1;
    @(negedge clk);
    clr_we = 1'b0; clr_din = 3'b000; src_in = 3'b000;
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL clr_alone: got %b want 000", pending); end
    @(negedge clk);
    pc_cur = 32'h0000_6000; src_in = 3'b001; inst_retire = 1'b1;
    expQ.push_back(mkTake(2'd0, 32'h0000_6000));
    for (int i = 0; i < 8 && takeCnt < base + 1; i++) @(negedge clk);
    src_in = 3'b010;
    repeat (2) @(negedge clk);
    checks++; if (pending !== 3'b010) begin errors++; $display("FAIL lower_prio_waits: got %b want 010", pending); end
    checks++; if (in_service !== 1'b1) begin errors++; $display("FAIL pre_reset_insvc: got %b want 1", in_service); end
    reset = 1'b0; src_in = 3'b000; inst_retire = 1'b0;
    @(negedge clk);
    checks++; if (in_service !== 1'b0) begin errors++; $display("FAIL midrst_insvc: got %b want 0", in_service); end
    checks++; if (pending !== 3'b000) begin errors++; $display("FAIL midrst_pending: got %b want 000", pending); end
    checks++; if (epc !== 32'h0) begin errors++; $display("FAIL midrst_epc: got %h want 0", epc); end
    checks++; if (irq_vec !== 32'h800) begin errors++; $display("FAIL midrst_vec: got %h want 00000800", irq_vec); end
    checks++; if (irq_id !== 2'd0) begin errors++; $display("FAIL midrst_id: got %0d want 0", irq_id); end
    checks++; if (irq_take !== 1'b0) begin errors++; $display("FAIL midrst_take: got %b want 0", irq_take); end
    reset = 1'b1; inst_retire = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (takeCnt !== base + 1) begin errors++; $display("FAIL reset_exit_take: got %0d takes want %0d", takeCnt, base + 1); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_nested();
    test_full();
    test_eret_and_mask();
    test_clr_and_reset();
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL missing_takes: got %0d outstanding want 0", expQ.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
